pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Generic parametrised inter-stage pipeline register, the successor to the fixed per-stage latches (fetch/decode, decode/execute, ...).
- Carries an opaque WIDTH-bit payload with a valid/ready handshake, synchronous flush for branch/exception kill, and an optional 2-entry skid buffer.
- When SKID=1, in_ready_o is fully registered and timing paths are broken.
- Instantiated once per stage boundary in the core pipeline.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- CTRL_WIDTH, 4, number of low payload bits that are control strobes (rf_we, mem_we, ...); forced to 0 on out_data_o whenever out_valid_o=0 (0 <= CTRL_WIDTH <= WIDTH).
- SKID, 1, 0 = single register with combinational ready; 1 = main + skid register with registered ready.

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  kill all held entries and the current input this cycle
- in_valid_i  in  1  upstream payload valid
- in_ready_o  out  1  stage can accept this cycle
- in_data_i  in  WIDTH  upstream payload
- out_valid_o  out  1  payload valid to downstream
- out_ready_i  in  1  downstream accepts this cycle
- out_data_o  out  WIDTH  downstream payload

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - Sampled at posedge; all valid flags are cleared, so out_valid_o=0.
  - Data registers are reset to 0.
  - in_ready_o=1 in the cycle after reset when SKID=1.
  - Reset during a transfer discards all entries; no partial state survives.
- Handshake:
  - Upstream transfer when in_valid_i && in_ready_o.
  - Downstream transfer when out_valid_o && out_ready_i.
  - Payload stability: once out_valid_o=1, out_data_o and out_valid_o are held until the transfer completes or flush/reset occurs.
- Latency: 1 cycle. Data accepted at edge N appears on out_data_o after edge N when the stage was empty. Full throughput of 1 transfer per cycle in steady state.
- SKID=0:
  - in_ready_o = !out_valid_o || out_ready_i (combinational).
  - A single register is loaded on each upstream transfer.
  - out_valid_o is cleared on a downstream transfer with no simultaneous upstream transfer.
- SKID=1, states:
  - EMPTY (0 entries): in_ready_o=1, out_valid_o=0.
  - ONE (main valid): in_ready_o=1, out_valid_o=1.
  - TWO (main+skid valid): in_ready_o=0, out_valid_o=1.
- SKID=1, transitions:
  - EMPTY + in transfer -> ONE.
  - ONE + in only -> TWO; the new word goes to skid.
  - ONE + out only -> EMPTY.
  - ONE + in&out -> ONE; main takes the new word.
  - TWO + out -> ONE; the skid word moves to main.
- in_ready_o is a register output, equal to !(next state == TWO).
- Ordering is strict FIFO; a word is never duplicated or dropped except by flush/reset.
- Flush:
  - At the posedge where flush_i=1, all valid flags are cleared (state -> EMPTY).
  - Any simultaneous upstream word is discarded, even if in_ready_o=1.
  - A simultaneous downstream transfer still counts as completed on the downstream side.
  - Data registers are not cleared.
  - Priority: rst > flush_i > handshakes.
- Bubble masking: out_data_o[CTRL_WIDTH-1:0] = 0 whenever out_valid_o=0. Upper bits are unspecified-but-stable, and downstream must not rely on them.
- in_valid_i is permitted to drop without a transfer; the block holds no state for unaccepted input.

Decomposition:
- The shared pipeline package holds:
  - the per-boundary payload widths as localparams (e.g. DE_PAYLOAD_W);
  - the CTRL_WIDTH constants;
  - the state enum (PS_EMPTY, PS_ONE, PS_TWO).
- No sub-module is required. The SKID=0/1 variants are generate branches inside pipe_stage_reg.
- Stage-specific latches become thin wrappers that pack fields into in_data_i and unpack out_data_o.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid_i=1 -> out_valid_o=0, out_data_o[3:0]=0. The first cycle after rst deasserts gives in_ready_o=1 (SKID=1).
- Streaming: 8 words 0x100..0x107 with out_ready_i=1 continuously -> one word per cycle out, in order, first word 1 cycle after acceptance.
- Backpressure (SKID=1): hold out_ready_i=0 and push 0xA, 0xB -> in_ready_o=0 after the 2nd accept, 0xA is held stable. Release -> 0xA, then 0xB, then in_ready_o returns to 1.
- Flush with TWO entries and in_valid_i=1 carrying 0xC -> next cycle out_valid_o=0, ctrl bits 0, and 0xC never appears.
- Simultaneous in&out in ONE state: main=0x1, input 0x2 -> after the edge out_data_o=0x2 and state stays ONE.
- SKID=0 build: out_ready_i=0 with out_valid_o=1 -> in_ready_o=0 in the same cycle. Raising out_ready_i -> in_ready_o=1 combinationally, and 0x3/0x4 transfer back-to-back.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: per-boundary payload widths, control-strobe widths
// and the stage occupancy encoding.
package pipe_stage_reg_pkg;

  // Decode/execute boundary payload and its low control-strobe field
  localparam int unsigned DE_PAYLOAD_W = 32;
  localparam int unsigned DE_CTRL_W    = 4;

  // Default build uses the skid buffer so the upstream ready is a flop
  localparam bit PS_SKID_DEFAULT = 1'b1;

  // Number of valid entries held by a skid-buffered stage
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } ps_state_e;

endpackage : pipe_stage_reg_pkg

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: valid/ready handshake, synchronous
// flush, optional 2-entry skid buffer, control strobes masked on bubbles.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned WIDTH      = DE_PAYLOAD_W,
  parameter int unsigned CTRL_WIDTH = DE_CTRL_W,
  parameter bit          SKID       = PS_SKID_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  // Ones over the control-strobe field; shifting by WIDTH yields an all-ones mask
  localparam logic [WIDTH-1:0] CTRL_MASK = ~({WIDTH{1'b1}} << CTRL_WIDTH);

  logic             w_valid;
  logic [WIDTH-1:0] w_data;

  if (SKID) begin : g_skid
    ps_state_e        r_state;
    ps_state_e        w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_skid_to_main;

    assign w_in_xfer  = in_valid_i && r_in_ready;
    assign w_out_xfer = (r_state != PS_EMPTY) && out_ready_i;

    // Next occupancy and register-load selects; flush drops everything held and offered
    always_comb begin
      w_state_nxt    = r_state;
      w_load_main    = 1'b0;
      w_load_skid    = 1'b0;
      w_skid_to_main = 1'b0;
      case (r_state)
        PS_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = PS_ONE;
            w_load_main = 1'b1;
          end
        end
        PS_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_load_main = 1'b1;
          end else if (w_in_xfer) begin
            w_state_nxt = PS_TWO;
            w_load_skid = 1'b1;
          end else if (w_out_xfer) begin
            w_state_nxt = PS_EMPTY;
          end
        end
        PS_TWO: begin
          if (w_out_xfer) begin
            w_state_nxt    = PS_ONE;
            w_skid_to_main = 1'b1;
          end
        end
        default: w_state_nxt = PS_EMPTY;
      endcase
      if (flush_i) begin
        w_state_nxt    = PS_EMPTY;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
      end
    end

    // State, payload and registered upstream ready
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state    <= PS_EMPTY;
        r_main     <= '0;
        r_skid     <= '0;
        r_in_ready <= 1'b1;
      end else begin
        r_state    <= w_state_nxt;
        r_in_ready <= (w_state_nxt != PS_TWO);
        if (w_load_main) begin
          r_main <= in_data_i;
        end else if (w_skid_to_main) begin
          r_main <= r_skid;
        end
        if (w_load_skid) begin
          r_skid <= in_data_i;
        end
      end
    end

    assign w_valid    = (r_state != PS_EMPTY);
    assign w_data     = r_main;
    assign in_ready_o = r_in_ready;

  end else begin : g_single
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_in_ready;
    logic             w_in_xfer;

    assign w_in_ready = !r_valid || out_ready_i;
    assign w_in_xfer  = in_valid_i && w_in_ready;

    // Single holding register refilled on every accepted word
    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else begin
        if (flush_i) begin
          r_valid <= 1'b0;
        end else if (w_in_xfer) begin
          r_valid <= 1'b1;
        end else if (r_valid && out_ready_i) begin
          r_valid <= 1'b0;
        end
        if (w_in_xfer && !flush_i) begin
          r_data <= in_data_i;
        end
      end
    end

    assign w_valid    = r_valid;
    assign w_data     = r_data;
    assign in_ready_o = w_in_ready;
  end

  // Bubbles must never carry live control strobes downstream
  always_comb begin
    out_valid_o = w_valid;
    out_data_o  = w_valid ? w_data : (w_data & ~CTRL_MASK);
  end

endmodule : pipe_stage_reg
